// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REDIR = 2'd2
  } fstate_e;

  typedef struct packed {
    logic [31:0] pc_next;
    logic        en;
    logic        imem_req;
    logic        flush_d;
    logic        flush_e;
  } fetch_out_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (clear)                cnt_q <= '0;
    else if (inc && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC controller: picks the next PC, gates the PC register and
// holds a redirect target while instruction memory is not ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      PCF,
  input  logic [31:0]      PCPlus4F,
  input  logic             StallF,
  input  logic             PCSrcE,
  input  logic [31:0]      PCTargetE,
  input  logic             TrapReq,
  input  logic             IMemReady,
  output logic [31:0]      PCNextF,
  output logic             EN,
  output logic             IMemReq,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] RedirCnt
);
  fstate_e     state_q, state_d;
  logic [31:0] pend_q, pend_d;
  fetch_out_t  out;
  logic        redir_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    out         = '0;
    out.pc_next = PCPlus4F;
    redir_acc   = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        out.imem_req = 1'b1;
        if (TrapReq || PCSrcE) begin
          out.pc_next = TrapReq ? TRAP_VEC : PCTargetE;
          out.flush_d = 1'b1;
          out.flush_e = 1'b1;
          out.en      = IMemReady;
          redir_acc   = 1'b1;
          if (!IMemReady) begin
            pend_d  = out.pc_next;
            state_d = ST_REDIR;
          end
        end else if (!StallF) begin
          out.en = IMemReady;
        end
      end
      ST_REDIR: begin
        // Branch/stall inputs here belong to wrong-path instructions.
        out.imem_req = 1'b1;
        out.flush_d  = 1'b1;
        if (TrapReq) begin
          pend_d      = TRAP_VEC;
          out.flush_e = 1'b1;
          redir_acc   = 1'b1;
        end
        out.pc_next = pend_d;
        out.en      = IMemReady;
        if (IMemReady) state_d = ST_FETCH;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (redir_acc),
    .clear (1'b0),
    .cnt   (RedirCnt)
  );

  assign PCNextF = out.pc_next;
  assign EN      = out.en;
  assign IMemReq = out.imem_req;
  assign FlushD  = out.flush_d;
  assign FlushE  = out.flush_e;

`ifndef SYNTHESIS
  // The PC register must present a consistent PC / PC+4 pair.
  a_pc_plus4: assert property (@(posedge clk) disable iff (!reset_n)
    PCPlus4F == PCF + 32'd4);
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a cycle-level model checked every cycle, plus literal pins.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] PCF, PCPlus4F, PCTargetE;
  logic        StallF, PCSrcE, TrapReq, IMemReady;
  logic [31:0] PCNextF, PCNextF2;
  logic        EN, IMemReq, FlushD, FlushE;
  logic        EN2, IMemReq2, FlushD2, FlushE2;
  logic [15:0] RedirCnt;
  logic [1:0]  RedirCnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign PCPlus4F = PCF + 32'd4;

  fetch_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .TrapReq(TrapReq),
    .IMemReady(IMemReady), .PCNextF(PCNextF), .EN(EN), .IMemReq(IMemReq),
    .FlushD(FlushD), .FlushE(FlushE), .RedirCnt(RedirCnt)
  );

  fetch_ctrl #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .TrapReq(TrapReq),
    .IMemReady(IMemReady), .PCNextF(PCNextF2), .EN(EN2), .IMemReq(IMemReq2),
    .FlushD(FlushD2), .FlushE(FlushE2), .RedirCnt(RedirCnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: a post-reset bubble flag, an optional pending target, a redirect tally.
  bit          m_bubble = 1'b1, m_pend_v = 1'b0;
  logic [31:0] m_pend = '0;
  int          m_nred = 0;
  logic [31:0] e_nx;
  logic        e_en, e_req, e_fd, e_fe, e_chk_nx;
  logic [15:0] e_c1;
  logic [1:0]  e_c2;

  initial begin
    bit n_bubble, n_pend_v;
    logic [31:0] n_pend;
    int n_nred;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_bubble = 1'b1; m_pend_v = 1'b0; m_pend = '0; m_nred = 0;
      end
      n_bubble = 1'b0; n_pend_v = m_pend_v; n_pend = m_pend; n_nred = m_nred;
      e_nx = PCPlus4F; e_en = 0; e_req = 1; e_fd = 0; e_fe = 0; e_chk_nx = 1;
      if (m_bubble) begin
        e_req = 0;
      end else if (m_pend_v) begin
        n_pend   = TrapReq ? 32'h100 : m_pend;
        n_nred   = m_nred + (TrapReq ? 1 : 0);
        n_pend_v = !IMemReady;
        e_nx = n_pend; e_en = IMemReady; e_fd = 1; e_fe = TrapReq;
      end else if (TrapReq || PCSrcE) begin
        n_pend   = TrapReq ? 32'h100 : PCTargetE;
        n_nred   = m_nred + 1;
        n_pend_v = !IMemReady;
        e_nx = n_pend; e_en = IMemReady; e_fd = 1; e_fe = 1;
      end else if (StallF) begin
        e_chk_nx = 0;
      end else begin
        e_en = IMemReady;
      end
      e_c1 = 16'(m_nred);
      e_c2 = 2'(m_nred > 3 ? 3 : m_nred);
      if (!reset_n) begin
        n_bubble = 1'b1; n_pend_v = 1'b0; n_pend = '0; n_nred = 0;
      end
      chk("model.EN", EN, e_en);
      chk("model.IMemReq", IMemReq, e_req);
      chk("model.FlushD", FlushD, e_fd);
      chk("model.FlushE", FlushE, e_fe);
      if (e_chk_nx) chk("model.PCNextF", PCNextF, e_nx);
      chk("model.RedirCnt", RedirCnt, e_c1);
      chk("model.RedirCnt_w2", RedirCnt2, e_c2);
      @(posedge clk);
      if (reset_n) begin
        m_bubble = n_bubble; m_pend_v = n_pend_v; m_pend = n_pend; m_nred = n_nred;
      end
    end
  end

  task automatic drive(input bit t, input bit s, input logic [31:0] tg,
                       input bit st, input bit r, input logic [31:0] pc);
    @(posedge clk); #1;
    TrapReq = t; PCSrcE = s; PCTargetE = tg; StallF = st; IMemReady = r; PCF = pc;
    @(negedge clk); #1;
  endtask

  // Literal expectations, checked against both the DUT and the model.
  task automatic pin(input string nm, input bit en, input bit req, input bit fd,
                     input bit fe, input bit cnx, input logic [31:0] nx,
                     input int c1, input int c2);
    chk({nm, ".EN"}, EN, en);           chk({nm, ".m_EN"}, e_en, en);
    chk({nm, ".IMemReq"}, IMemReq, req); chk({nm, ".m_IMemReq"}, e_req, req);
    chk({nm, ".FlushD"}, FlushD, fd);    chk({nm, ".m_FlushD"}, e_fd, fd);
    chk({nm, ".FlushE"}, FlushE, fe);    chk({nm, ".m_FlushE"}, e_fe, fe);
    if (cnx) begin
      chk({nm, ".PCNextF"}, PCNextF, nx); chk({nm, ".m_PCNextF"}, e_nx, nx);
    end
    chk({nm, ".RedirCnt"}, RedirCnt, c1);     chk({nm, ".m_RedirCnt"}, e_c1, c1);
    chk({nm, ".RedirCnt_w2"}, RedirCnt2, c2); chk({nm, ".m_RedirCnt_w2"}, e_c2, c2);
  endtask

  initial begin
    reset_n = 0; PCF = 0; PCTargetE = 0; StallF = 0; PCSrcE = 0; TrapReq = 0; IMemReady = 1;
    repeat (2) @(negedge clk);
    #1 pin("reset", 0, 0, 0, 0, 1, 32'h4, 0, 0);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk); #1 pin("boot", 0, 0, 0, 0, 1, 32'h4, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0);        pin("first_fetch", 1, 1, 0, 0, 1, 32'h4, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h4);        pin("stall", 0, 1, 0, 0, 0, 32'h0, 0, 0);
    drive(0, 1, 32'h40, 1, 1, 32'h4);   pin("br_ready", 1, 1, 1, 1, 1, 32'h40, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h40);       pin("after_br", 1, 1, 0, 0, 1, 32'h44, 1, 1);
    drive(0, 1, 32'h80, 0, 0, 32'h44);  pin("br_wait", 0, 1, 1, 1, 1, 32'h80, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h999, 1, 0, 32'h44); pin("redir_hold", 0, 1, 1, 0, 1, 32'h80, 2, 2);
    end
    drive(0, 1, 32'h999, 1, 1, 32'h44); pin("redir_ack", 1, 1, 1, 0, 1, 32'h80, 2, 2);
    drive(0, 0, 0, 0, 1, 32'h80);       pin("back_fetch", 1, 1, 0, 0, 1, 32'h84, 2, 2);
    drive(0, 1, 32'h80, 0, 0, 32'h84);  pin("br_wait2", 0, 1, 1, 1, 1, 32'h80, 2, 2);
    drive(1, 0, 0, 0, 0, 32'h84);       pin("redir_trap", 0, 1, 1, 1, 1, 32'h100, 3, 3);
    drive(0, 0, 0, 0, 1, 32'h84);       pin("trap_ack", 1, 1, 1, 0, 1, 32'h100, 4, 3);
    drive(1, 1, 32'h40, 0, 1, 32'h100); pin("trap_over_br", 1, 1, 1, 1, 1, 32'h100, 4, 3);
    drive(0, 0, 0, 0, 1, 32'h100);      pin("sat_five", 1, 1, 0, 0, 1, 32'h104, 5, 3);
    drive(1, 0, 0, 0, 0, 32'h104);      pin("trap_wait", 0, 1, 1, 1, 1, 32'h100, 5, 3);
    drive(0, 0, 0, 0, 1, 32'h104);      pin("trap_wait_ack", 1, 1, 1, 0, 1, 32'h100, 6, 3);
    drive(0, 1, 32'h200, 0, 0, 32'h100); pin("br_wait3", 0, 1, 1, 1, 1, 32'h200, 6, 3);
    drive(0, 0, 0, 0, 0, 32'h100);      pin("redir_pre_rst", 0, 1, 1, 0, 1, 32'h200, 7, 3);
    @(posedge clk); #1 reset_n = 0;
    @(negedge clk); #1 pin("rst_in_redir", 0, 0, 0, 0, 1, 32'h104, 0, 0);
    @(posedge clk); #1 reset_n = 1; IMemReady = 1;
    @(negedge clk); #1 pin("boot2", 0, 0, 0, 0, 1, 32'h104, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h100);      pin("no_flush_after_rst", 1, 1, 0, 0, 1, 32'h104, 0, 0);
    for (int i = 0; i < 80; i++)
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, {$urandom_range(0, 255), 2'b00},
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, {$urandom_range(0, 1023), 2'b00});
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
